// File: rtl/pixel_frame_streamer.sv
// pixel_frame_streamer
// Buffers one WIDTH x HEIGHT grayscale frame, loaded one pixel per wr_en,
// then replays it in raster order as a valid/ready stream with coordinates
// and frame/line markers. The buffer is retained, so every start replays
// the same frame. Loading a new frame requires rst.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset (back to LOAD, outputs cleared)
//   wr_en      load strobe, one pixel per cycle while loading
//   wr_data    pixel written at the current load address
//   load_full  high once all WIDTH*HEIGHT pixels have been written
//   start      request to begin streaming, honoured only when armed
//   out_valid  beat on out_data/out_x/out_y/flags is valid
//   out_ready  downstream accepts a beat when out_valid & out_ready
//   out_data   pixel value
//   out_x      column 0..WIDTH-1
//   out_y      row 0..HEIGHT-1
//   out_sof    first pixel of the frame
//   out_eol    last pixel of a line
//   out_eof    last pixel of the frame
//   frame_done one-cycle pulse after the eof beat is accepted
//   busy       streaming (including inter-line gaps)
module pixel_frame_streamer #(
   parameter int WIDTH    = 80,
   parameter int HEIGHT   = 40,
   parameter int DW       = 8,
   parameter int LINE_GAP = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   output logic          load_full,
   input  logic          start,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [6:0]    out_x,
   output logic [5:0]    out_y,
   output logic          out_sof,
   output logic          out_eol,
   output logic          out_eof,
   output logic          frame_done,
   output logic          busy
);

   localparam int DEPTH = WIDTH * HEIGHT;
   localparam int AW    = $clog2(DEPTH + 1);

   localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
   localparam logic [6:0]    X_LAST    = 7'(WIDTH - 1);
   localparam logic [5:0]    Y_LAST    = 6'(HEIGHT - 1);
   localparam bit            HAS_GAP   = (LINE_GAP > 0);
   localparam logic [3:0]    GAP_LAST  = HAS_GAP ? 4'(LINE_GAP - 1) : 4'd0;

   localparam logic [2:0] S_LOAD   = 3'd0;
   localparam logic [2:0] S_ARMED  = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_GAP    = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]    state_reg;
   logic [AW-1:0] wr_addr_reg;

   // Fetch side: address and coordinates of the next pixel to read.
   logic [AW-1:0] rd_addr_reg;
   logic [6:0]    fetch_x_reg;
   logic [5:0]    fetch_y_reg;
   logic          fetch_active_reg;

   // Prefetch stage: memory read register plus the coordinates it belongs to.
   logic [DW-1:0] pre_data_reg;
   logic [6:0]    pre_x_reg;
   logic [5:0]    pre_y_reg;
   logic          pre_valid_reg;

   // Output stage.
   logic          out_valid_reg;
   logic [DW-1:0] out_data_reg;
   logic [6:0]    out_x_reg;
   logic [5:0]    out_y_reg;

   logic [3:0]    gap_cnt_reg;

   logic [DW-1:0] mem [0:DEPTH-1];

   logic accept;
   logic line_end;
   logic frame_end;
   logic start_go;
   logic wr_go;
   logic load_out;
   logic rd_en;

   assign accept    = out_valid_reg & out_ready;
   assign line_end  = (out_x_reg == X_LAST);
   assign frame_end = line_end && (out_y_reg == Y_LAST);
   assign start_go  = (state_reg == S_ARMED) && start;
   assign wr_go     = (state_reg == S_LOAD) && wr_en;

   // Move the prefetched pixel into the output register when the output
   // slot is empty or is being emptied this cycle. An accepted end-of-line
   // beat with a gap configured leaves the slot empty; the gap counter
   // refills it later from the still-held prefetch stage.
   always_comb begin
      load_out = 1'b0;
      if (pre_valid_reg) begin
         if (state_reg == S_STREAM)
            load_out = !out_valid_reg || (accept && !(HAS_GAP && line_end));
         else if (state_reg == S_GAP)
            load_out = (gap_cnt_reg == GAP_LAST);
      end
   end

   // The first read is issued on the start cycle itself (rd_addr is 0 while
   // armed); afterwards the prefetch stage is refilled whenever it drains.
   assign rd_en = start_go || (fetch_active_reg && (!pre_valid_reg || load_out));

   // Frame buffer: write port used only while loading, registered read.
   always_ff @(posedge clk) begin
      if (wr_go)
         mem[wr_addr_reg] <= wr_data;
      if (rd_en)
         pre_data_reg <= mem[rd_addr_reg];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= S_LOAD;
         wr_addr_reg      <= '0;
         rd_addr_reg      <= '0;
         fetch_x_reg      <= '0;
         fetch_y_reg      <= '0;
         fetch_active_reg <= 1'b0;
         pre_x_reg        <= '0;
         pre_y_reg        <= '0;
         pre_valid_reg    <= 1'b0;
         out_valid_reg    <= 1'b0;
         out_data_reg     <= '0;
         out_x_reg        <= '0;
         out_y_reg        <= '0;
         gap_cnt_reg      <= '0;
      end else begin
         case (state_reg)
            S_LOAD: begin
               if (wr_go) begin
                  if (wr_addr_reg == ADDR_LAST) begin
                     wr_addr_reg <= '0;
                     state_reg   <= S_ARMED;
                  end else begin
                     wr_addr_reg <= wr_addr_reg + 1'b1;
                  end
               end
            end
            S_ARMED: begin
               if (start)
                  state_reg <= S_STREAM;
            end
            S_STREAM: begin
               if (accept && frame_end) begin
                  state_reg <= S_DONE;
               end else if (accept && line_end && HAS_GAP) begin
                  state_reg   <= S_GAP;
                  gap_cnt_reg <= '0;
               end
            end
            S_GAP: begin
               if (gap_cnt_reg == GAP_LAST)
                  state_reg <= S_STREAM;
               else
                  gap_cnt_reg <= gap_cnt_reg + 4'd1;
            end
            default: begin
               // S_DONE lasts one cycle; start is only sampled once armed.
               state_reg <= S_ARMED;
            end
         endcase

         if (rd_en) begin
            pre_valid_reg <= 1'b1;
            pre_x_reg     <= fetch_x_reg;
            pre_y_reg     <= fetch_y_reg;
            if (rd_addr_reg == ADDR_LAST) begin
               // Last pixel fetched: rewind so the next start reads from 0.
               rd_addr_reg      <= '0;
               fetch_x_reg      <= '0;
               fetch_y_reg      <= '0;
               fetch_active_reg <= 1'b0;
            end else begin
               rd_addr_reg      <= rd_addr_reg + 1'b1;
               fetch_active_reg <= 1'b1;
               if (fetch_x_reg == X_LAST) begin
                  fetch_x_reg <= '0;
                  fetch_y_reg <= fetch_y_reg + 6'd1;
               end else begin
                  fetch_x_reg <= fetch_x_reg + 7'd1;
               end
            end
         end else if (load_out) begin
            pre_valid_reg <= 1'b0;
         end

         if (load_out) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= pre_data_reg;
            out_x_reg     <= pre_x_reg;
            out_y_reg     <= pre_y_reg;
         end else if (accept) begin
            out_valid_reg <= 1'b0;
            if (frame_end) begin
               out_x_reg <= '0;
               out_y_reg <= '0;
            end
         end
      end
   end

   assign out_valid  = out_valid_reg;
   assign out_data   = out_data_reg;
   assign out_x      = out_x_reg;
   assign out_y      = out_y_reg;
   assign out_sof    = out_valid_reg && (out_x_reg == 7'd0) && (out_y_reg == 6'd0);
   assign out_eol    = out_valid_reg && line_end;
   assign out_eof    = out_valid_reg && frame_end;
   assign load_full  = (state_reg != S_LOAD);
   assign frame_done = (state_reg == S_DONE);
   assign busy       = (state_reg == S_STREAM) || (state_reg == S_GAP);

endmodule
